counter_seq_ctrl: RTL and testbench

Sequencing controller for a WIDTH-bit synchronous counter datapath. It accepts a configuration (terminal limit, direction, one-shot or auto-reload) over a valid/ready handshake. It then runs, pauses, resumes or aborts the count under start/stop/abort commands, and flags terminal count. It sits between a host/FSM and the counter, so no other logic drives the counter directly.

---
 rtl/counter_seq_pkg.sv | 24 ++
 rtl/counter_seq_ctrl_updown_counter.sv | 33 +++
 rtl/counter_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_counter_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// ============================================================================
// Module   : counter_seq_pkg
// Purpose  : Shared state encoding and direction constants for the counter
//            sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package counter_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/counter_seq_ctrl_updown_counter.sv
// ============================================================================
// Module   : updown_counter
// Purpose  : Loadable up/down counter; load has priority over enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module updown_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic             load,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);
    import counter_seq_pkg::*;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (dir == DIR_DOWN) ? count - 1'b1 : count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
// ============================================================================
// Module   : counter_seq_ctrl
// Purpose  : Config handshake, run/pause/abort sequencing and terminal-count
//            detection in front of an up/down counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module counter_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_dir,
    input  logic             cfg_reload,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);
    import counter_seq_pkg::*;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   limit;
    logic               dir;
    logic               reload;
    logic               tc_next;
    logic               cnt_load;
    logic               cnt_en;
    logic [WIDTH-1:0]   cnt_load_val;
    logic [WIDTH-1:0]   start_val;
    logic               at_terminal;
    logic               cfg_accept;

    assign cfg_ready   = (state == S_IDLE) || (state == S_ARMED) || (state == S_DONE);
    assign busy        = (state == S_RUN) || (state == S_PAUSE);
    assign done        = (state == S_DONE);
    // Abort outranks a config handshake presented on the same edge.
    assign cfg_accept  = cfg_valid && cfg_ready && !abort;
    assign start_val   = (dir == DIR_DOWN) ? limit : '0;
    assign at_terminal = (dir == DIR_DOWN) ? (count == '0) : (count == limit);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state  <= S_IDLE;
            limit  <= '0;
            dir    <= DIR_UP;
            reload <= 1'b0;
            tc     <= 1'b0;
        end else begin
            state <= state_next;
            tc    <= tc_next;
            if (cfg_accept) begin
                limit  <= cfg_limit;
                dir    <= cfg_dir;
                reload <= cfg_reload;
            end
        end
    end

    always_comb begin
        state_next   = state;
        tc_next      = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = start_val;
        if (abort) begin
            state_next   = S_IDLE;
            cnt_load     = 1'b1;
            cnt_load_val = '0;
        end else if (cfg_accept) begin
            state_next   = S_ARMED;
            cnt_load     = 1'b1;
            cnt_load_val = (cfg_dir == DIR_DOWN) ? cfg_limit : '0;
        end else begin
            case (state)
                S_ARMED: begin
                    if (start) state_next = S_RUN;
                end
                S_DONE: begin
                    if (start) begin
                        state_next = S_RUN;
                        cnt_load   = 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_next = S_PAUSE;
                    end else if (at_terminal) begin
                        tc_next = 1'b1;
                        if (reload) cnt_load   = 1'b1;
                        else        state_next = S_DONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (start) state_next = S_RUN;
                end
                default: state_next = state;
            endcase
        end
    end

    updown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .clear_n  (clear_n),
        .en       (cnt_en),
        .load     (cnt_load),
        .dir      (dir),
        .load_val (cnt_load_val),
        .count    (count)
    );

endmodule

`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
// ============================================================================
// Module   : tb_counter_seq_ctrl
// Purpose  : Directed self-checking bench for counter_seq_ctrl (WIDTH = 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_limit = 3'd0;
    logic       cfg_dir = 1'b0;
    logic       cfg_reload = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] count;
    logic       busy;
    logic       tc;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.WIDTH(3)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_limit  (cfg_limit),
        .cfg_dir    (cfg_dir),
        .cfg_reload (cfg_reload),
        .start      (start),
        .stop       (stop),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [2:0] lim, input logic d, input logic rl);
        cfg_valid = 1'b1; cfg_limit = lim; cfg_dir = d; cfg_reload = rl;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (count !== 3'd0 || cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d rdy=%b busy=%b done=%b tc=%b, want 0 1 0 0 0",
                     count, cfg_ready, busy, done, tc);
        end
        clear_n = 1'b1;
        tick();
        go();
        checks++;
        if (count !== 3'd0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_start: count=%0d busy=%b rdy=%b, want 0 0 1", count, busy, cfg_ready);
        end
    endtask

    task automatic test_oneshot_up();
        configure(3'd5, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL armed_up: count=%0d busy=%b rdy=%b, want 0 0 1", count, busy, cfg_ready);
        end
        go();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (count !== 3'(i) || busy !== 1'b1 || tc !== 1'b0) begin
                errors++;
                $display("FAIL up_run[%0d]: count=%0d busy=%b tc=%b, want %0d 1 0", i, count, busy, tc, i);
            end
            tick();
        end
        checks++;
        if (tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || count !== 3'd5) begin
            errors++;
            $display("FAIL up_term: tc=%b done=%b busy=%b count=%0d, want 1 1 0 5", tc, done, busy, count);
        end
        tick();
        checks++;
        if (tc !== 1'b0 || done !== 1'b1 || count !== 3'd5) begin
            errors++;
            $display("FAIL up_hold: tc=%b done=%b count=%0d, want 0 1 5", tc, done, count);
        end
        go();
        checks++;
        if (count !== 3'd0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL up_restart: count=%0d busy=%b done=%b, want 0 1 0", count, busy, done);
        end
        do_abort();
    endtask

    task automatic test_reload_down();
        logic [2:0] exp_cnt;
        logic       exp_tc;
        configure(3'd3, 1'b1, 1'b1);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL armed_down: count=%0d, want 3", count);
        end
        go();
        for (int k = 0; k < 10; k++) begin
            exp_cnt = 3'(3 - (k % 4));
            exp_tc  = (k >= 4) && (k % 4 == 0);
            checks++;
            if (count !== exp_cnt || tc !== exp_tc || done !== 1'b0) begin
                errors++;
                $display("FAIL down_run[%0d]: count=%0d tc=%b done=%b, want %0d %b 0",
                         k, count, tc, done, exp_cnt, exp_tc);
            end
            tick();
        end
        do_abort();
    endtask

    task automatic test_pause_resume();
        configure(3'd6, 1'b0, 1'b0);
        go();
        tick();
        tick();
        stop = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (count !== 3'd2 || busy !== 1'b1 || cfg_ready !== 1'b0 || tc !== 1'b0) begin
                errors++;
                $display("FAIL pause[%0d]: count=%0d busy=%b rdy=%b tc=%b, want 2 1 0 0",
                         i, count, busy, cfg_ready, tc);
            end
            tick();
        end
        stop = 1'b0;
        go();
        tick();
        checks++;
        if (count !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL resume: count=%0d busy=%b, want 3 1", count, busy);
        end
        do_abort();
    endtask

    task automatic test_abort_cfg();
        configure(3'd5, 1'b0, 1'b0);
        go();
        cfg_valid = 1'b1; cfg_limit = 3'd1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_rdy: cfg_ready=%b, want 0", cfg_ready);
        end
        tick(); tick(); tick();
        cfg_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || tc !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ignored: count=%0d tc=%b busy=%b, want 3 0 1", count, tc, busy);
        end
        do_abort();
        checks++;
        if (count !== 3'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL abort: count=%0d busy=%b rdy=%b done=%b tc=%b, want 0 0 1 0 0",
                     count, busy, cfg_ready, done, tc);
        end
        go();
        checks++;
        if (busy !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL abort_needs_cfg: busy=%b count=%0d, want 0 0", busy, count);
        end
        configure(3'd5, 1'b0, 1'b0);
        go();
        tick(); tick();
        clear_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || tc !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d busy=%b rdy=%b tc=%b done=%b, want 0 0 1 0 0",
                     count, busy, cfg_ready, tc, done);
        end
        clear_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: busy=%b count=%0d, want 0 0", busy, count);
        end
    endtask

    task automatic test_boundaries();
        configure(3'd7, 1'b0, 1'b1);
        go();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (count !== 3'(k % 8) || tc !== (k == 8)) begin
                errors++;
                $display("FAIL max_run[%0d]: count=%0d tc=%b, want %0d %b", k, count, tc, k % 8, k == 8);
            end
            tick();
        end
        do_abort();
        configure(3'd0, 1'b0, 1'b0);
        go();
        checks++;
        if (busy !== 1'b1 || tc !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL lim0_run: busy=%b tc=%b count=%0d, want 1 0 0", busy, tc, count);
        end
        tick();
        checks++;
        if (done !== 1'b1 || tc !== 1'b1 || busy !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL lim0_done: done=%b tc=%b busy=%b count=%0d, want 1 1 0 0", done, tc, busy, count);
        end
        configure(3'd4, 1'b0, 1'b0);
        go();
        tick();
        abort = 1'b1; stop = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; stop = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== 3'd0 || cfg_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_prio: busy=%b count=%0d rdy=%b done=%b, want 0 0 1 0",
                     busy, count, cfg_ready, done);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot_up();
        test_reload_down();
        test_pause_resume();
        test_abort_cfg();
        test_boundaries();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
